tim_cc_array: RTL

//  NUM_CH-wide capture/compare array for the general-purpose timer; one slice per channel.

---
 rtl/tim_cc_array.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/tim_cc_array.sv
// Capture/compare array for the general-purpose timer: one input-capture / output-compare slice per channel.
// Optional input glitch filter is enabled by defining TIM_ICFILT_EN.
module tim_cc_array #(
  parameter int NUM_CH    = 4,
  parameter int CNT_WIDTH = 32,
  parameter int CCR_WIDTH = 32
) (
  input  logic                          clk_i,
  input  logic                          aresetn_i,
  input  logic [CNT_WIDTH-1:0]          cnt_i,
  input  logic                          dir_i,
  input  logic                          uev_i,
  input  logic [NUM_CH-1:0]             ti_i,
  input  logic [2*NUM_CH-1:0]           ccs_i,
  input  logic [NUM_CH-1:0]             ccp_i,
  input  logic [NUM_CH-1:0]             ccnp_i,
  input  logic [2*NUM_CH-1:0]           icps_i,
  input  logic [4*NUM_CH-1:0]           icf_i,
  input  logic [3*NUM_CH-1:0]           ocm_i,
  input  logic [NUM_CH-1:0]             ocpe_i,
  input  logic [NUM_CH-1:0]             cce_i,
  input  logic [NUM_CH-1:0]             ccg_i,
  input  logic [NUM_CH-1:0]             ccr_wr_i,
  input  logic [CCR_WIDTH-1:0]          ccr_wdata_i,
  input  logic [NUM_CH-1:0]             ccif_clr_i,
  input  logic [NUM_CH-1:0]             ccof_clr_i,
  output logic [NUM_CH*CCR_WIDTH-1:0]   ccr_o,
  output logic [NUM_CH-1:0]             ccif_o,
  output logic [NUM_CH-1:0]             ccof_o,
  output logic [NUM_CH-1:0]             oc_ref_o,
  output logic [NUM_CH-1:0]             oc_o
);

  logic [NUM_CH-1:0] sync1_r;
  logic [NUM_CH-1:0] sync2_r;

  // Two-flop synchroniser for the asynchronous channel inputs.
  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      sync1_r <= '0;
      sync2_r <= '0;
    end else begin
      sync1_r <= ti_i;
      sync2_r <= sync1_r;
    end
  end

`ifndef TIM_ICFILT_EN
  logic unused_icf_s;
  assign unused_icf_s = ^icf_i;
`endif

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    localparam int NB_RAW = g ^ 1;
    localparam int NB     = (NB_RAW >= NUM_CH) ? g : NB_RAW;

    logic [1:0]           ccs_s;
    logic [2:0]           ocm_s;
    logic                 in_mode_s;
    logic                 out_mode_s;
    logic                 sel_s;
    logic                 filt_s;
    logic                 rise_s;
    logic                 fall_s;
    logic                 evt_s;
    logic                 psc_run_s;
    logic [2:0]           div_m1_s;
    logic                 strobe_s;
    logic                 cap_s;
    logic                 set_s;
    logic                 match_s;
    logic                 pwm_s;
    logic                 ref_nxt_s;
    logic [CCR_WIDTH-1:0] cnt_ext_s;

    logic                 hist_r;
    logic [2:0]           psc_r;
    logic [CCR_WIDTH-1:0] ccr_r;
    logic [CCR_WIDTH-1:0] act_r;
    logic                 match_r;
    logic                 ref_r;
    logic                 oc_r;
    logic                 ccif_r;
    logic                 ccof_r;

    assign ccs_s      = ccs_i[2*g +: 2];
    assign ocm_s      = ocm_i[3*g +: 3];
    assign in_mode_s  = (ccs_s == 2'b01) || (ccs_s == 2'b10);
    assign out_mode_s = (ccs_s == 2'b00);
    assign sel_s      = (ccs_s == 2'b10) ? sync2_r[NB] : sync2_r[g];
    assign cnt_ext_s  = CCR_WIDTH'(cnt_i);

`ifdef TIM_ICFILT_EN
    logic [3:0] icf_s;
    logic [3:0] fcnt_r;
    logic       fval_r;

    assign icf_s = icf_i[4*g +: 4];

    // Filtered level only follows the input after it has differed for icf cycles in a row.
    always_ff @(posedge clk_i or negedge aresetn_i) begin
      if (!aresetn_i) begin
        fcnt_r <= 4'd0;
        fval_r <= 1'b0;
      end else if (icf_s == 4'd0) begin
        fcnt_r <= 4'd0;
        fval_r <= sel_s;
      end else if (sel_s == fval_r) begin
        fcnt_r <= 4'd0;
      end else if (fcnt_r == (icf_s - 4'd1)) begin
        fcnt_r <= 4'd0;
        fval_r <= sel_s;
      end else begin
        fcnt_r <= fcnt_r + 4'd1;
      end
    end

    assign filt_s = (icf_s == 4'd0) ? sel_s : fval_r;
`else
    assign filt_s = sel_s;
`endif

    assign rise_s = filt_s & ~hist_r;
    assign fall_s = ~filt_s & hist_r;

    always_comb begin
      evt_s = 1'b0;
      case ({ccp_i[g], ccnp_i[g]})
        2'b10:   evt_s = fall_s;
        2'b11:   evt_s = rise_s | fall_s;
        default: evt_s = rise_s;
      endcase
    end

    always_comb begin
      div_m1_s = 3'd0;
      case (icps_i[2*g +: 2])
        2'b01:   div_m1_s = 3'd1;
        2'b10:   div_m1_s = 3'd3;
        2'b11:   div_m1_s = 3'd7;
        default: div_m1_s = 3'd0;
      endcase
    end

    assign psc_run_s = cce_i[g] & in_mode_s;
    assign strobe_s  = psc_run_s & evt_s & (psc_r == div_m1_s);
    // Software capture bypasses both the prescaler and the channel enable.
    assign cap_s     = in_mode_s & (strobe_s | ccg_i[g]);
    assign match_s   = out_mode_s & (cnt_ext_s == act_r);
    assign set_s     = cap_s | (out_mode_s & ((match_s & ~match_r) | ccg_i[g]));
    assign pwm_s     = dir_i ? (cnt_ext_s <= act_r) : (cnt_ext_s < act_r);

    always_comb begin
      ref_nxt_s = ref_r;
      if (out_mode_s) begin
        case (ocm_s)
          3'b001:  ref_nxt_s = match_s ? 1'b1 : ref_r;
          3'b010:  ref_nxt_s = match_s ? 1'b0 : ref_r;
          3'b011:  ref_nxt_s = (match_s & ~match_r) ? ~ref_r : ref_r;
          3'b100:  ref_nxt_s = 1'b0;
          3'b101:  ref_nxt_s = 1'b1;
          3'b110:  ref_nxt_s = pwm_s;
          3'b111:  ref_nxt_s = ~pwm_s;
          default: ref_nxt_s = ref_r;
        endcase
      end else begin
        ref_nxt_s = ref_r;
      end
    end

    // Slice state: edge history, prescaler, CCR/active CCR, reference and flags.
    always_ff @(posedge clk_i or negedge aresetn_i) begin
      if (!aresetn_i) begin
        hist_r  <= 1'b0;
        psc_r   <= 3'd0;
        ccr_r   <= '0;
        act_r   <= '0;
        match_r <= 1'b0;
        ref_r   <= 1'b0;
        oc_r    <= 1'b0;
        ccif_r  <= 1'b0;
        ccof_r  <= 1'b0;
      end else begin
        hist_r <= filt_s;
        if (!psc_run_s) begin
          psc_r <= 3'd0;
        end else if (strobe_s) begin
          psc_r <= 3'd0;
        end else if (evt_s) begin
          psc_r <= psc_r + 3'd1;
        end
        if (cap_s) begin
          ccr_r <= cnt_ext_s;
        end else if (out_mode_s && ccr_wr_i[g]) begin
          ccr_r <= ccr_wdata_i;
        end
        // Active CCR copies the pre-edge CCR, so a write coinciding with uev is not yet seen.
        if (out_mode_s && (!ocpe_i[g] || uev_i)) begin
          act_r <= ccr_r;
        end
        match_r <= match_s;
        ref_r   <= ref_nxt_s;
        oc_r    <= cce_i[g] & (ref_nxt_s ^ ccp_i[g]);
        if (set_s) begin
          ccif_r <= 1'b1;
        end else if (ccif_clr_i[g]) begin
          ccif_r <= 1'b0;
        end
        if (cap_s && ccif_r && !ccif_clr_i[g]) begin
          ccof_r <= 1'b1;
        end else if (ccof_clr_i[g]) begin
          ccof_r <= 1'b0;
        end
      end
    end

    assign ccr_o[g*CCR_WIDTH +: CCR_WIDTH] = ccr_r;
    assign ccif_o[g]   = ccif_r;
    assign ccof_o[g]   = ccof_r;
    assign oc_ref_o[g] = ref_r;
    assign oc_o[g]     = oc_r;
  end

endmodule
